// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART command decoder issuing single 32-bit bus transactions
module uart_bus_master #(
  parameter int unsigned BUS_TIMEOUT  = 1024,
  parameter int unsigned IDLE_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_overrun
);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam int unsigned MAX_T = (BUS_TIMEOUT > IDLE_TIMEOUT) ? BUS_TIMEOUT : IDLE_TIMEOUT;
  localparam int CW = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] BUS_LAST  = CW'(BUS_TIMEOUT - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_BUS, S_SEND, S_WAIT_DONE
  } state_t;

  state_t        r_state;
  logic          r_write;
  logic          r_nak;
  logic          r_data_phase;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic [7:0]    w_resp_byte;
  logic          w_no_accept;

  // Status byte first; read data follows from r_rdata once r_data_phase is set.
  always_comb begin
    w_resp_byte = r_nak ? NAK : ACK;
    if (r_data_phase) begin
      w_resp_byte = r_rdata[{r_idx, 3'b000} +: 8];
    end
  end

  assign w_no_accept = (r_state == S_BUS) || (r_state == S_SEND) || (r_state == S_WAIT_DONE);
  assign o_busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_nak        <= 1'b0;
      r_data_phase <= 1'b0;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_rdata      <= 32'h0;
      o_tx_data    <= 8'h0;
      o_tx_start   <= 1'b0;
      o_mem_valid  <= 1'b0;
      o_mem_addr   <= 32'h0;
      o_mem_wdata  <= 32'h0;
      o_mem_wstrb  <= 4'h0;
      o_overrun    <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_overrun  <= i_rx_valid && w_no_accept;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_W || i_rx_data == CMD_R) begin
              r_write <= (i_rx_data == CMD_W);
              r_idx   <= 2'd0;
              r_cnt   <= '0;
              r_state <= S_ADDR;
            end else begin
              r_nak        <= 1'b1;
              r_data_phase <= 1'b0;
              r_state      <= S_SEND;
            end
          end
        end
        S_ADDR, S_WDATA: begin
          if (i_rx_valid) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
            if (r_state == S_ADDR) begin
              o_mem_addr <= {i_rx_data, o_mem_addr[31:8]};
            end else begin
              o_mem_wdata <= {i_rx_data, o_mem_wdata[31:8]};
            end
            if (r_idx == 2'd3) begin
              if (r_state == S_ADDR && r_write) begin
                r_state <= S_WDATA;
              end else begin
                o_mem_valid <= 1'b1;
                o_mem_wstrb <= r_write ? 4'hF : 4'h0;
                r_state     <= S_BUS;
              end
            end
          end else if (r_cnt == IDLE_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BUS: begin
          if (i_mem_ready) begin
            o_mem_valid  <= 1'b0;
            o_mem_wstrb  <= 4'h0;
            r_rdata      <= i_mem_rdata;
            r_nak        <= 1'b0;
            r_data_phase <= 1'b0;
            r_state      <= S_SEND;
          end else if (r_cnt == BUS_LAST) begin
            o_mem_valid  <= 1'b0;
            o_mem_wstrb  <= 4'h0;
            r_nak        <= 1'b1;
            r_data_phase <= 1'b0;
            r_state      <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SEND: begin
          o_tx_data  <= w_resp_byte;
          o_tx_start <= 1'b1;
          r_state    <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_tx_done) begin
            if (!r_data_phase && !r_nak && !r_write) begin
              r_data_phase <= 1'b1;
              r_idx        <= 2'd0;
              r_state      <= S_SEND;
            end else if (r_data_phase && r_idx != 2'd3) begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_SEND;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - randomized self-checking bench for uart_bus_master
module tb_uart_bus_master;
  localparam int BT = 16;
  localparam int IT = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        tx_done = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_mem_valid;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        o_busy;
  logic        o_overrun;

  uart_bus_master #(.BUS_TIMEOUT(BT), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(tx_done),
    .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  tx_q[$];
  logic [67:0] bus_q[$];
  int rdy_delay = -1;
  int rdy_cnt = 0;
  int mv_len = 0;
  int last_mv_len = 0;
  int tx_cnt = 0;
  int tx_lat_min = 1;
  int tx_lat_max = 4;
  int ovr_cnt = 0;
  int unstable = 0;
  int gap_err = 0;
  logic mv_prev = 1'b0;
  logic tx_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural uart_tx and bus responder, plus observers, all acting on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          tx_busy = 1'b0;
        end
      end
      if (o_tx_start) begin
        if (tx_busy) gap_err++;
        tx_q.push_back(o_tx_data);
        tx_busy = 1'b1;
        tx_cnt = $urandom_range(tx_lat_min, tx_lat_max);
      end
      mem_ready = 1'b0;
      if (o_mem_valid) begin
        if (!mv_prev) begin
          bus_q.push_back({o_mem_addr, o_mem_wdata, o_mem_wstrb});
          mv_len = 0;
          rdy_cnt = rdy_delay;
        end else if ({o_mem_addr, o_mem_wdata, o_mem_wstrb} != bus_q[$]) begin
          unstable++;
        end
        mv_len++;
        if (rdy_cnt == 0) mem_ready = 1'b1;
        rdy_cnt--;
      end else if (mv_prev) begin
        last_mv_len = mv_len;
      end
      mv_prev = o_mem_valid;
      if (o_overrun) ovr_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay);
    logic [7:0] exp_tx[$];
    bit is_cmd, is_wr, ok, done;
    is_cmd = (cmd == 8'h57) || (cmd == 8'h52);
    is_wr  = (cmd == 8'h57);
    ok     = is_cmd && delay >= 0 && delay < BT;
    if (!ok) begin
      exp_tx.push_back(8'h15);
    end else begin
      exp_tx.push_back(8'h06);
      if (!is_wr) for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
    end
    rdy_delay = delay;
    mem_rdata = rdata;
    tx_q.delete();
    bus_q.delete();
    unstable = 0;
    gap_err = 0;
    send_byte(cmd);
    if (is_cmd) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(addr[8*i +: 8]);
      end
      if (is_wr) begin
        for (int i = 0; i < 4; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_byte(wdata[8*i +: 8]);
        end
      end
      check("valid_latency", o_mem_valid, 1);
    end
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      done = !o_busy && !tx_busy && (tx_q.size() >= exp_tx.size());
    end
    check("resp_done", done, 1);
    check("tx_count", tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("tx_byte%0d", i), tx_q[i], exp_tx[i]);
    check("tx_gap", gap_err, 0);
    check("bus_count", bus_q.size(), is_cmd);
    if (is_cmd && bus_q.size() == 1) begin
      check("mem_addr", bus_q[0][67:36], addr);
      check("mem_wstrb", bus_q[0][3:0], is_wr ? 4'hF : 4'h0);
      if (is_wr) check("mem_wdata", bus_q[0][35:4], wdata);
      check("valid_cycles", last_mv_len, ok ? delay + 1 : BT);
      check("bus_stable", unstable, 0);
    end
  endtask

  initial begin
    logic [7:0] cmd;
    int pick, dly, ovr0;
    bit seen;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {o_tx_data, o_tx_start, o_mem_valid, o_mem_wstrb, o_busy, o_overrun}, 0);
    check("reset_addr", o_mem_addr, 0);
    check("reset_wdata", o_mem_wdata, 0);
    reset_n = 1'b1;

    run_frame(8'h57, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0, 3);
    run_frame(8'h52, 32'h2000_0008, 32'h0, 32'h1234_5678, 2);
    run_frame(8'h41, 32'h0, 32'h0, 32'h0, 0);
    run_frame(8'h52, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, -1);
    run_frame(8'h52, 32'h0000_0104, 32'h0, 32'hA5A5_5A5A, BT - 1);

    tx_q.delete();
    bus_q.delete();
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    repeat (IT - 1) @(negedge clk);
    check("idle_busy_before", o_busy, 1);
    @(negedge clk);
    check("idle_busy_after", o_busy, 0);
    check("idle_no_tx", tx_q.size(), 0);
    check("idle_no_bus", bus_q.size(), 0);
    run_frame(8'h52, $urandom, 32'h0, $urandom, 1);

    tx_lat_min = 8;
    tx_lat_max = 8;
    tx_q.delete();
    ovr0 = ovr_cnt;
    send_byte(8'h41);
    for (int c = 0; c < 20 && tx_q.size() == 0; c++) @(negedge clk);
    check("ovr_tx_started", tx_q.size(), 1);
    send_byte(8'h52);
    @(negedge clk);
    check("ovr_pulse", ovr_cnt - ovr0, 1);
    check("ovr_busy_held", o_busy, 1);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = !o_busy;
    end
    check("ovr_back_idle", seen, 1);
    repeat (3) @(negedge clk);
    check("ovr_stays_idle", o_busy, 0);
    check("ovr_tx_only_nak", tx_q.size(), 1);
    check("ovr_nak", tx_q[0], 8'h15);
    tx_lat_min = 1;
    tx_lat_max = 4;

    for (int n = 0; n < 24; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4) cmd = 8'h57;
      else if (pick < 8) cmd = 8'h52;
      else begin
        cmd = $urandom;
        if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'hFF;
      end
      pick = $urandom_range(0, 7);
      dly = (pick < 5) ? pick : (pick == 5) ? BT - 1 : (pick == 6) ? -1 : BT;
      run_frame(cmd, $urandom, $urandom, $urandom, dly);
    end

    rdy_delay = -1;
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
    repeat (3) @(negedge clk);
    check("rst_pre_valid", o_mem_valid, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_ctrl", {o_tx_start, o_mem_valid, o_mem_wstrb, o_busy, o_overrun}, 0);
    check("rst_async_addr", o_mem_addr, 0);
    check("rst_async_tx", o_tx_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(8'h57, $urandom, $urandom, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial debug bridge and bus initiator, the counterpart of the memory-mapped UART responder.
- Consumes a byte stream from a uart_rx instance and decodes read/write commands.
- Issues single 32-bit transactions on the native valid/ready memory bus, and returns status/data bytes through a uart_tx instance.
- Sits beside the CPU as a second bus initiator. External arbitration is out of scope.

Parameters:
- BUS_TIMEOUT, 1024: cycles mem_valid may stay high without mem_ready before abort; must be ≥ 1.
- IDLE_TIMEOUT, 100000: max cycles between bytes of one command before the frame is discarded; must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse, start transmission of tx_data
- tx_done  in  1  one-cycle pulse, byte fully sent
- mem_valid  out  1  bus request
- mem_addr  out  32  bus address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_ready  in  1  responder completion
- mem_rdata  in  32  read data, valid with mem_ready
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  one-cycle pulse: rx byte dropped

Behaviour:
- Reset (async, reset_n low): every output is 0; FSM is in IDLE; counters are 0.
- Frame formats:
  - Write: 0x57 ('W'), addr[4], data[4].
  - Read: 0x52 ('R'), addr[4].
  - Multi-byte fields are little-endian: first byte received is bits [7:0].
- Responses:
  - Write success: ACK 0x06.
  - Read success: ACK 0x06, then rdata[4] little-endian.
  - Failure: NAK 0x15 only.
- States: IDLE, ADDR, WDATA, BUS, SEND, WAIT_DONE. A 2-bit byte index is shared by ADDR, WDATA and SEND.
- IDLE:
  - rx_valid with 0x57 or 0x52 → latch op, index = 0, go to ADDR.
  - Any other byte → queue NAK, go to SEND.
- ADDR: each rx_valid shifts a byte into mem_addr. After the 4th byte:
  - write → WDATA;
  - read → BUS.
- WDATA: same byte handling into mem_wdata. After the 4th byte → BUS.
- Bus request timing: mem_valid rises the cycle after the last operand byte's rx_valid.
  - mem_wstrb = 4'hF for write, 4'h0 for read.
  - mem_addr is passed unmodified; no alignment check.
- BUS:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until completion.
  - mem_ready sampled high → mem_valid and mem_wstrb drop next cycle; read data is latched; ACK is queued; go to SEND.
  - Cycle counter reaches BUS_TIMEOUT with no mem_ready → mem_valid drops, NAK is queued, go to SEND.
  - If mem_ready and timeout expiry coincide, mem_ready wins.
- SEND: tx_data is driven and tx_start pulses for exactly one cycle; go to WAIT_DONE.
- WAIT_DONE: on tx_done, if response bytes remain, advance the index and return to SEND; otherwise go to IDLE.
  - tx_data holds its value until the next SEND.
  - Consecutive tx_start pulses are always separated by a tx_done.
- Inter-byte timeout: in ADDR/WDATA the idle counter clears on each rx_valid. When it reaches IDLE_TIMEOUT, the FSM returns to IDLE silently, with no response and no bus activity.
- rx_valid in BUS, SEND or WAIT_DONE: the byte is discarded and overrun pulses for 1 cycle. The FSM is unaffected.
- Reset asserted mid-transaction: mem_valid and tx_start drop immediately (async). After release, the FSM restarts in IDLE.
- Throughput: one command outstanding at a time; no pipelining.

Test Plan:
- Write: rx 57 10 00 00 20 EF BE AD DE.
  - mem_valid rises 1 cycle after the last byte, with addr 0x20000010, wdata 0xDEADBEEF, wstrb F.
  - Responder delays ready by 3 cycles → single tx byte 0x06; busy low after tx_done.
- Read: rx 52 08 00 00 20; responder returns 0x12345678.
  - wstrb 0.
  - tx sequence 06 78 56 34 12, each tx_start pulse gated by the prior tx_done.
- Unknown command: rx 0x41 → tx 0x15; no mem_valid.
- Bus timeout: read with mem_ready held low.
  - mem_valid stays high exactly BUS_TIMEOUT cycles, then drops; tx 0x15.
  - Repeat with mem_ready asserted on the expiry cycle → ACK path taken.
- Inter-byte timeout: rx 57 10 00, then silence for IDLE_TIMEOUT cycles.
  - Returns to IDLE with no tx and no bus activity.
  - A following complete read frame succeeds.
- Overrun and reset: a byte arriving during WAIT_DONE → overrun pulse and no state change. reset_n pulsed low during BUS → all outputs 0 asynchronously.
